// File: rtl/hirose_core_arbiter_if.sv
// Requester/response bus between host logic and the Hirose core arbiter.
// The master side issues jobs and consumes results; the arbiter is the slave.
interface hirose_core_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int HASH_WIDTH = 128
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [ID_W-1:0]             resp_id;
    logic [HASH_WIDTH-1:0]       resp_hash;
    logic                        resp_timeout;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_hash, resp_timeout
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_hash, resp_timeout
    );
endinterface

// File: rtl/hirose_core_arbiter.sv
// Round-robin job arbiter sharing one Hirose-PRESENT compression core.
// Each job: reset the core, drive the latched block, wait for end or timeout.
module hirose_core_arbiter #(
    parameter int N_REQ          = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int HASH_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RST_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    hirose_core_arbiter_if.slave  bus,
    output logic                  busy,
    output logic                  core_rst,
    output logic [DATA_WIDTH-1:0] core_plaintext,
    input  logic                  core_end,
    input  logic [HASH_WIDTH-1:0] core_hash
);
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    generate
        if (HASH_WIDTH != 2 * DATA_WIDTH) begin : g_bad_hash_width
            $error("HASH_WIDTH must equal 2*DATA_WIDTH");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
            $error("N_REQ must be in 2..8");
        end
        if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
            $error("RST_CYCLES and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [ID_W-1:0]       last_reg, last_next;
    logic [ID_W-1:0]       id_reg, id_next;
    logic [DATA_WIDTH-1:0] pt_reg, pt_next;
    logic [HASH_WIDTH-1:0] hash_reg, hash_next;
    logic                  timeout_reg, timeout_next;

    logic [DATA_WIDTH-1:0] blk [N_REQ];
    logic                  grant_found;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign blk[gi]           = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.req_ready[gi] = grant_valid && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Search starts one past the last winner, so a continuously valid set rotates.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_id     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_reg) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_id = ID_W'(cand);
            if (!grant_found && bus.req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    assign grant_valid = (state_reg == IDLE) && grant_found;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_next    = last_reg;
        id_next      = id_reg;
        pt_next      = pt_reg;
        hash_next    = hash_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    pt_next    = blk[grant_idx];
                    id_next    = grant_idx;
                    last_next  = grant_idx;
                    cnt_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RUN: begin
                // A core finish in the last allowed cycle still counts as success.
                if (core_end) begin
                    hash_next    = core_hash;
                    timeout_next = 1'b0;
                    state_next   = RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    hash_next    = '0;
                    timeout_next = 1'b1;
                    state_next   = RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            last_reg    <= ID_W'(N_REQ - 1);
            id_reg      <= '0;
            pt_reg      <= '0;
            hash_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_reg    <= last_next;
            id_reg      <= id_next;
            pt_reg      <= pt_next;
            hash_reg    <= hash_next;
            timeout_reg <= timeout_next;
        end
    end

    // The core sits in reset everywhere except RUN.
    assign core_rst         = (state_reg != RUN);
    assign busy             = (state_reg != IDLE);
    assign core_plaintext   = pt_reg;
    assign bus.resp_valid   = (state_reg == RESP);
    assign bus.resp_id      = id_reg;
    assign bus.resp_hash    = hash_reg;
    assign bus.resp_timeout = timeout_reg;

endmodule
